mux2x1_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 mux (mux2x1) between two requesters. It owns the mux select line and issues one-hot grants. A requester holds its grant while its request stays high, but loses it after MAX_HOLD consecutive grant cycles if the other side is waiting. It sits directly in front of the mux's select input, one instance per shared mux.

---
 rtl/mux2x1_arbiter_if.sv | 39 +++
 rtl/mux2x1_arbiter.sv | 91 +++++++++
 tb/tb_mux2x1_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mux2x1_arbiter_if.sv
// Request/grant bundle between two requesters and the mux2x1 arbiter.
// Latency: none, wires only.
// Backpressure: none; requests are levels held while in use, grants are registered by the arbiter.
interface mux2x1_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             req0;
    logic             req1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             busy;
    logic             switch;
    logic [CNT_W-1:0] hold_cnt;

    // Requester side: drives requests, observes grants and mux select.
    modport master (
        output req0,
        output req1,
        input  gnt0,
        input  gnt1,
        input  sel,
        input  busy,
        input  switch,
        input  hold_cnt
    );

    // Arbiter side.
    modport slave (
        input  req0,
        input  req1,
        output gnt0,
        output gnt1,
        output sel,
        output busy,
        output switch,
        output hold_cnt
    );
endinterface

// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter owning the select line of one shared 2:1 mux, with a hold limit under contention.
// Latency: one cycle from request to grant and sel; no combinational req-to-gnt path.
// Backpressure: a granted requester keeps the mux while requesting, preempted after MAX_HOLD cycles if the other waits.
module mux2x1_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux2x1_arbiter_if.slave       bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    // Counter value at which a contested grant is handed over.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;      // last requester served; loser of the next tie
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             sel_q, sel_d;
    logic             switch_q, switch_d;
    logic             entering;

    // Next grant owner from current owner, requests and hold count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) state_d = last_q ? GRANT0 : GRANT1;
                else if (bus.req0)        state_d = GRANT0;
                else if (bus.req1)        state_d = GRANT1;
                else                      state_d = IDLE;
            end
            GRANT0: begin
                if (!bus.req0)                         state_d = bus.req1 ? GRANT1 : IDLE;
                else if (bus.req1 && hold_cnt_q == HOLD_LAST) state_d = GRANT1;
                else                                   state_d = GRANT0;
            end
            GRANT1: begin
                if (!bus.req1)                         state_d = bus.req0 ? GRANT0 : IDLE;
                else if (bus.req0 && hold_cnt_q == HOLD_LAST) state_d = GRANT0;
                else                                   state_d = GRANT1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, hold counter, and a sel that only moves on grant entry so the mux never glitches in IDLE.
    always_comb begin
        entering   = (state_d != IDLE) && (state_d != state_q);
        last_d     = last_q;
        hold_cnt_d = '0;
        sel_d      = sel_q;
        if (entering) begin
            last_d     = (state_d == GRANT1);
            sel_d      = (state_d == GRANT1);
            hold_cnt_d = '0;
        end else if (state_d != IDLE) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
        switch_d = (sel_d != sel_q);
    end

    // Registered arbiter state with synchronous reset; a reset mid-grant simply drops the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            sel_q      <= 1'b0;
            switch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            switch_q   <= switch_d;
        end
    end

    assign bus.gnt0     = (state_q == GRANT0);
    assign bus.gnt1     = (state_q == GRANT1);
    assign bus.busy     = (state_q == GRANT0) || (state_q == GRANT1);
    assign bus.sel      = sel_q;
    assign bus.switch   = switch_q;
    assign bus.hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Directed bench for mux2x1_arbiter with a per-cycle reference model and hand-computed spot checks.
// Latency: model predicts registered outputs after each rising edge; checks sample on the falling edge.
// Backpressure: not applicable; requests are driven as levels.
module tb_mux2x1_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    bit   cmp_en;

    mux2x1_arbiter_if #(.CNT_W(CNT_W)) bus ();

    mux2x1_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared mux driven by the arbiter's select: i0 = 1, i1 = 0.
    logic mux_i0, mux_i1, mux_out;
    assign mux_i0  = 1'b1;
    assign mux_i1  = 1'b0;
    assign mux_out = bus.sel ? mux_i1 : mux_i0;

    // Reference model: who owns the mux (-1 = nobody), how long, who went last.
    int m_owner;
    int m_cnt;
    int m_last;
    int m_sel;
    int m_sw;

    always @(posedge clk) begin
        int nxt;
        int rq[2];
        rq[0] = int'(bus.req0);
        rq[1] = int'(bus.req1);
        if (!rst_n) begin
            m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 0; m_sw = 0;
        end else begin
            if (m_owner < 0) begin
                if (rq[0] == 1 && rq[1] == 1) nxt = 1 - m_last;
                else if (rq[0] == 1)          nxt = 0;
                else if (rq[1] == 1)          nxt = 1;
                else                          nxt = -1;
            end else begin
                if (rq[m_owner] == 0)
                    nxt = (rq[1 - m_owner] == 1) ? 1 - m_owner : -1;
                else if (rq[1 - m_owner] == 1 && m_cnt + 1 >= MAX_HOLD)
                    nxt = 1 - m_owner;
                else
                    nxt = m_owner;
            end
            if (nxt < 0) begin
                m_cnt = 0;
                m_sw  = 0;
            end else if (nxt != m_owner) begin
                m_cnt  = 0;
                m_last = nxt;
                m_sw   = (nxt != m_sel) ? 1 : 0;
                m_sel  = nxt;
            end else begin
                m_cnt = (m_cnt + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_cnt + 1;
                m_sw  = 0;
            end
            m_owner = nxt;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_gnt0",   int'(bus.gnt0),     (m_owner == 0) ? 1 : 0);
            check("m_gnt1",   int'(bus.gnt1),     (m_owner == 1) ? 1 : 0);
            check("m_busy",   int'(bus.busy),     (m_owner >= 0) ? 1 : 0);
            check("m_sel",    int'(bus.sel),      m_sel);
            check("m_switch", int'(bus.switch),   m_sw);
            check("m_hold",   int'(bus.hold_cnt), m_cnt);
            check("m_onehot", int'(bus.gnt0 & bus.gnt1), 0);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_all(input string name, input int g0, input int g1, input int s,
                             input int b, input int sw, input int h);
        check({name, ".gnt0"},   int'(bus.gnt0),     g0);
        check({name, ".gnt1"},   int'(bus.gnt1),     g1);
        check({name, ".sel"},    int'(bus.sel),      s);
        check({name, ".busy"},   int'(bus.busy),     b);
        check({name, ".switch"}, int'(bus.switch),   sw);
        check({name, ".hold"},   int'(bus.hold_cnt), h);
    endtask

    initial begin
        tests = 0; fails = 0; cmp_en = 1'b0;
        m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 0; m_sw = 0;
        rst_n = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Reset, no requests.
        cyc(2);
        cmp_en = 1'b1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check_all("idle", 0, 0, 0, 0, 0, 0);
        end

        // Tie after reset: req0 first, preempted after 8 cycles each way.
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            int e0;
            cyc(1);
            e0 = (k <= 8 || k == 17) ? 1 : 0;
            check("tie_gnt0", int'(bus.gnt0), e0);
            check("tie_gnt1", int'(bus.gnt1), 1 - e0);
            check("tie_switch", int'(bus.switch), (k == 9 || k == 17) ? 1 : 0);
            check("tie_hold", int'(bus.hold_cnt), (k <= 8) ? k - 1 : (k <= 16 ? k - 9 : 0));
            check("tie_mux", int'(mux_out), e0);
        end

        // Back to idle, then uncontested req1 for 20 cycles.
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cyc(1);
        check_all("drop", 0, 0, 0, 0, 0, 0);
        bus.req1 = 1'b1;
        cyc(1);
        check_all("unc_enter", 0, 1, 1, 1, 1, 0);
        cyc(19);
        check_all("unc_sat", 0, 1, 1, 1, 0, 7);
        bus.req1 = 1'b0;
        cyc(1);
        check_all("unc_drop", 0, 0, 1, 0, 0, 0);

        // Direct handover from req0 to req1 with no idle gap.
        bus.req0 = 1'b1;
        cyc(1);
        check_all("ho_g0", 1, 0, 0, 1, 1, 0);
        cyc(2);
        check_all("ho_hold", 1, 0, 0, 1, 0, 2);
        bus.req0 = 1'b0; bus.req1 = 1'b1;
        cyc(1);
        check_all("ho_g1", 0, 1, 1, 1, 1, 0);

        // Reset mid-grant at hold_cnt = 3, both requests high.
        bus.req0 = 1'b1;
        cyc(3);
        check_all("mid_hold", 0, 1, 1, 1, 0, 3);
        rst_n = 1'b0;
        cyc(1);
        check_all("mid_rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1);
        check_all("post_rst", 1, 0, 0, 1, 0, 0);

        // Tail of free-running contention, checked by the model only.
        cyc(12);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
